// File: rtl/dev_timer.sv
// Bus-mapped down-counting timer: CTRL/PRESET/COUNT/PRESC registers, IRQ out.
// Optional prescaler compiled in with `define TIMER_PRESCALE_EN.
module dev_timer #(
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_n;
  logic        irq_flag;
  logic        flag_set;
  logic        en_clr;
  logic        tick;

  logic en;
  logic im;
  logic reload;
  logic ctrl_wr;
  logic preset_wr;

  assign en        = ctrl[0];
  assign im        = ctrl[3];
  assign reload    = (ctrl[2:1] == 2'b01);
  assign ctrl_wr   = WE && (Addr == 2'd0);
  assign preset_wr = WE && (Addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] psc_cnt;

  assign tick = (psc_cnt == presc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      psc_cnt <= '0;
    end else begin
      if (WE && (Addr == 2'd3))
        presc <= DIn[PRESC_W-1:0];
      if (state == LOAD)
        psc_cnt <= '0;
      else if (state == CNT)
        psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    flag_set = 1'b0;
    en_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (en)
          state_n = LOAD;
      end
      LOAD: begin
        count_n = preset;
        state_n = CNT;
      end
      CNT: begin
        if (!en) begin
          state_n = IDLE;
        end else if (count == 32'd0) begin
          state_n  = INT;
          flag_set = !reload;
        end else if (tick) begin
          count_n = count - 32'd1;
          if (count == 32'd1) begin
            state_n  = INT;
            flag_set = !reload;
          end
        end
      end
      INT: begin
        if (reload) begin
          state_n = LOAD;
        end else begin
          en_clr  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A bus write to CTRL beats the FSM's one-shot Enable clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      count <= count_n;
      if (preset_wr)
        preset <= DIn;
      if (ctrl_wr)
        ctrl <= DIn[3:0];
      else if (en_clr)
        ctrl[0] <= 1'b0;
      if (ctrl_wr)
        irq_flag <= 1'b0;
      else if (flag_set)
        irq_flag <= 1'b1;
    end
  end

  assign IRQ = im && (irq_flag || ((state == INT) && reload));

  always_comb begin
    DOut = '0;
    unique case (Addr)
      2'd0: DOut = {28'd0, ctrl};
      2'd1: DOut = preset;
      2'd2: DOut = count;
`ifdef TIMER_PRESCALE_EN
      2'd3: DOut = {{(32-PRESC_W){1'b0}}, presc};
`else
      2'd3: DOut = {{(32-PRESC_W){1'b0}}, {PRESC_W{1'b0}}};
`endif
    endcase
  end

endmodule

// File: tb/tb_dev_timer.sv
// Directed bench for dev_timer: expected register/IRQ values queued per step
// and compared by immediate assertions when the DUT is sampled.
`timescale 1ns/1ps
module tb_dev_timer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [1:0]  addr;
    bit          irq;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];

  dev_timer #(.PRESC_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Addr    (Addr),
    .WE      (WE),
    .DIn     (DIn),
    .DOut    (DOut),
    .IRQ     (IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic push(input string tag, input bit irq,
                      input logic [1:0] a, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.irq  = irq;
    e.addr = a;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e    = q.pop_front();
      Addr = e.addr;
      #1;
      obs = e.irq ? {31'd0, IRQ} : DOut;
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    DIn  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  initial begin
    int k;
    logic [31:0] cseq [5];
    cseq[0] = 3; cseq[1] = 2; cseq[2] = 1; cseq[3] = 0; cseq[4] = 0;

    reset_n = 1'b0;
    WE      = 1'b0;
    Addr    = 2'd0;
    DIn     = '0;
    #3;
    push("rst_ctrl", 0, 2'd0, 0);
    push("rst_preset", 0, 2'd1, 0);
    push("rst_count", 0, 2'd2, 0);
    push("rst_presc", 0, 2'd3, 0);
    push("rst_irq", 1, 2'd0, 0);
    drain();
    #5 reset_n = 1'b1;

    // one-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    push("os_ctrl", 0, 2'd0, 32'h9);
    push("os_preset", 0, 2'd1, 32'd5);
    drain();
    step(2);
    push("os_load", 0, 2'd2, 32'd5);
    drain();
    step(4);
    push("os_e6_count", 0, 2'd2, 32'd1);
    push("os_e6_irq", 1, 2'd0, 0);
    drain();
    step(1);
    push("os_e7_count", 0, 2'd2, 32'd0);
    push("os_e7_irq", 1, 2'd0, 1);
    drain();
    step(1);
    push("os_ctrl_clr", 0, 2'd0, 32'h8);
    push("os_irq_hold", 1, 2'd0, 1);
    drain();
    step(3);
    push("os_irq_hold2", 1, 2'd0, 1);
    drain();
    wr(2'd0, 32'h8);
    push("os_irq_cleared", 1, 2'd0, 0);
    drain();

    // auto-reload, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    step(1);
    for (int t = 2; t <= 12; t++) begin
      step(1);
      k = (t - 2) % 5;
      push("ar_count", 0, 2'd2, cseq[k]);
      push("ar_irq", 1, 2'd0, {31'd0, k == 3});
      drain();
    end
    wr(2'd0, 32'h0);
    step(2);

    // disable while COUNT=2, then write COUNT
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(4);
    wr(2'd0, 32'h0);
    push("dis_count", 0, 2'd2, 32'd2);
    push("dis_irq", 1, 2'd0, 0);
    push("dis_ctrl", 0, 2'd0, 0);
    drain();
    step(3);
    push("dis_hold", 0, 2'd2, 32'd2);
    drain();
    wr(2'd2, 32'h77);
    push("count_ro", 0, 2'd2, 32'd2);
    drain();

    // masked one-shot expiry, then CTRL write clears flag
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    step(3);
    push("im0_count", 0, 2'd2, 0);
    push("im0_irq", 1, 2'd0, 0);
    drain();
    step(1);
    push("im0_ctrl", 0, 2'd0, 0);
    drain();
    wr(2'd0, 32'h8);
    push("im0_flag_clr", 1, 2'd0, 0);
    push("im0_ctrl8", 0, 2'd0, 32'h8);
    drain();
    step(2);
    push("im0_flag_clr2", 1, 2'd0, 0);
    drain();

    // mode 10 behaves as one-shot
    wr(2'd0, 32'hD);
    step(3);
    push("m10_irq", 1, 2'd0, 1);
    drain();
    step(1);
    push("m10_ctrl", 0, 2'd0, 32'hC);
    push("m10_irq_hold", 1, 2'd0, 1);
    drain();
    wr(2'd0, 32'h8);

    // PRESET=0 expires on first CNT edge
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(2);
    push("p0_irq_pre", 1, 2'd0, 0);
    push("p0_count", 0, 2'd2, 0);
    drain();
    step(1);
    push("p0_irq", 1, 2'd0, 1);
    drain();
    #2 reset_n = 1'b0;
    push("arst_irq", 1, 2'd0, 0);
    push("arst_ctrl", 0, 2'd0, 0);
    drain();
    reset_n = 1'b1;

    // reset between edges mid-count
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(4);
    push("mid_count", 0, 2'd2, 32'd3);
    drain();
    #3 reset_n = 1'b0;
    push("mid_ctrl", 0, 2'd0, 0);
    push("mid_preset", 0, 2'd1, 0);
    push("mid_count0", 0, 2'd2, 0);
    push("mid_presc", 0, 2'd3, 0);
    push("mid_irq", 1, 2'd0, 0);
    drain();
    reset_n = 1'b1;
    step(8);
    push("mid_no_resume", 0, 2'd2, 0);
    push("mid_ctrl_idle", 0, 2'd0, 0);
    push("mid_irq_idle", 1, 2'd0, 0);
    drain();

`ifdef TIMER_PRESCALE_EN
    wr(2'd3, 32'd1);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    push("psc_rd", 0, 2'd3, 32'd1);
    drain();
    step(5);
    push("psc_count", 0, 2'd2, 32'd1);
    push("psc_irq_pre", 1, 2'd0, 0);
    drain();
    step(1);
    push("psc_count0", 0, 2'd2, 0);
    push("psc_irq", 1, 2'd0, 1);
    drain();
`else
    wr(2'd3, 32'hFF);
    push("presc_absent", 0, 2'd3, 0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
